fifo_ptr_ctrl: RTL
==================

Name: fifo_ptr_ctrl

Overview:
Write/read access controller for the 16-deep synchronous FIFO. It accepts raw wr/rd requests and qualifies them into the fwe/frd strobes. It generates the 5-bit wrap-bit pointers wptr/rptr consumed by the FIFO status logic, and owns the storage array and the registered read-data path. It sits between the producer/consumer request interface and the status-flag block.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, storage address bits; depth = 2**ADDR_WIDTH (16); pointers are ADDR_WIDTH+1 bits

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
wr  input  1  write request from producer
rd  input  1  read request from consumer
flush  input  1  synchronous clear of FIFO contents
data_in  input  DATA_WIDTH  write data, sampled when fwe=1
data_out  output  DATA_WIDTH  registered read data
rd_valid  output  1  data_out updated this cycle (one cycle after frd)
fwe  output  1  qualified write strobe = wr & ~full & ~flush
frd  output  1  qualified read strobe = rd & ~empty & ~flush
wptr  output  ADDR_WIDTH+1  write pointer, MSB is wrap bit
rptr  output  ADDR_WIDTH+1  read pointer, MSB is wrap bit
count  output  ADDR_WIDTH+1  occupancy, 0..16
full  output  1  FIFO holds 16 words
empty  output  1  FIFO holds 0 words

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately): wptr=0, rptr=0, data_out=0, rd_valid=0. Hence count=0, empty=1, full=0, fwe=0, frd=0. Storage contents are not reset.
- Release of rst is synchronised by the caller; the first accepted access is on the first rising edge with rst=0.
- full = (wptr[MSB] != rptr[MSB]) & (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]); combinational from the registered pointers.
- empty = (wptr == rptr); combinational.
- count = wptr - rptr, modulo 2**(ADDR_WIDTH+1); combinational.
- fwe, frd: combinational; a request blocked by full, empty or flush is dropped, not queued.
- On a rising edge with fwe=1: mem[wptr[ADDR_WIDTH-1:0]] <= data_in; wptr <= wptr+1 (wraps 31->0 naturally).
- On a rising edge with frd=1: data_out <= mem[rptr[ADDR_WIDTH-1:0]]; rptr <= rptr+1. rd_valid <= frd every edge.
- Read latency is 1 cycle: data_out and rd_valid are valid in the cycle after frd. data_out holds its last value when rd_valid=0.
- Simultaneous wr & rd, neither full nor empty: both proceed, count unchanged.
- Simultaneous wr & rd when full: read proceeds, write dropped (full evaluated before the edge); next state count=15.
- Simultaneous wr & rd when empty: write proceeds, read dropped (no fall-through); next state count=1, rd_valid=0.
- Write to a location being read in the same cycle cannot occur, because the addresses are equal only when full or empty.
- flush=1 on a rising edge: wptr <= 0, rptr <= 0, rd_valid <= 0, data_out unchanged. flush has priority over wr/rd, and fwe/frd are forced to 0 while flush=1.
- rst asserted mid-operation: all state clears as at reset, in-flight reads are discarded, and rd_valid drops immediately.
- Pointer wrap: after 16 writes and 16 reads, wptr=rptr=16 (MSB=1, low bits 0) and empty=1. Wrap-bit arithmetic keeps count correct across the 31->0 rollover.

Test Plan:
- Reset then idle -> wptr=0, rptr=0, count=0, empty=1, full=0, rd_valid=0, data_out=0.
- Write 0x01..0x10 (16 words) -> full=1 after 16th edge, count=16, wptr=16. A 17th wr gives fwe=0 and wptr stays 16.
- From full, read 16 times -> data_out sequence 0x01..0x10 each one cycle after frd with rd_valid=1. Afterwards empty=1, rptr=16, and a 17th rd gives frd=0, rd_valid=0 next cycle.
- From empty, assert wr=1 rd=1 with data_in=0xA5 -> fwe=1, frd=0, count=1. Next cycle wr=1 rd=1, data_in=0x5A -> count stays 1 and data_out=0xA5 with rd_valid=1.
- Fill to count=16, then wr=1 rd=1 -> frd=1, fwe=0, count=15. Run 40 write/read pairs across the 31->0 pointer rollover -> count constant, data order preserved.
- Write 5 words, pulse flush -> wptr=rptr=0, empty=1, rd_valid=0. Then assert rst mid-burst -> immediate clear of pointers, data_out=0.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// Access controller for a 16-deep synchronous FIFO: qualifies wr/rd requests,
// keeps wrap-bit pointers, holds the storage array and the registered read path.
module fifo_ptr_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  fwe,
    output logic                  frd,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Status and qualified strobes, all derived from the registered pointers
    always_comb begin
        full  = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
        empty = (wptr_q == rptr_q);
        count = wptr_q - rptr_q;
        fwe   = wr & ~full & ~flush;
        frd   = rd & ~empty & ~flush;
    end

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        data_out_d = data_out_q;
        rd_valid_d = frd;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (fwe) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (frd) begin
                rptr_d     = rptr_q + PTR_W'(1);
                data_out_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (fwe) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    assign wptr     = wptr_q;
    assign rptr     = rptr_q;
    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule
